exec_unit_xy: RTL and testbench

- Operational (execution) unit driven by the microcommands t1..t9 that a control automaton emits.
- Returns the condition flags x and y that the automaton consumes on its next decision.
- Holds an accumulator A, an operand register B, an iteration counter N and an output register DOUT.
- Sits directly opposite the controller, on the same clk and res.

---
 rtl/exec_unit_xy_if.sv | 24 ++
 rtl/exec_unit_xy.sv | 105 ++++++++++
 tb/tb_exec_unit_xy.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_xy_if.sv
// Microcommand/flag bus between the control automaton (master) and exec_unit_xy (slave).
// Carries t1..t9, the operand bus, the result register and the condition/status flags.
interface exec_unit_xy_if #(
  parameter int WIDTH = 8
);
  logic             t1, t2, t3, t4, t5, t6, t7, t8, t9;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             done;
  logic             x;
  logic             y;
  logic             err;
  logic             ovf;

  modport master (
    output t1, t2, t3, t4, t5, t6, t7, t8, t9, din,
    input  dout, done, x, y, err, ovf
  );

  modport slave (
    input  t1, t2, t3, t4, t5, t6, t7, t8, t9, din,
    output dout, done, x, y, err, ovf
  );
endinterface

// File: rtl/exec_unit_xy.sv
// Execution unit driven by microcommands t1..t9: accumulator A, operand B, counter N, output DOUT.
// Optional sticky signed-overflow flag enabled by defining OVF_FLAG_EN (otherwise ovf is tied low).
module exec_unit_xy #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input logic           clk,
  input logic           res,
  exec_unit_xy_if.slave bus
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CW-1:0]    n;
  logic [WIDTH-1:0] dout_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // A path: only the highest-priority command is applied (t1 > t3 > t4 > t7 > t8).
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a <= '0;
    end else if (bus.t1) begin
      a <= bus.din;
    end else if (bus.t3) begin
      a <= sum;
    end else if (bus.t4) begin
      a <= diff;
    end else if (bus.t7) begin
      a <= {a[WIDTH-2:0], 1'b0};
    end else if (bus.t8) begin
      a <= {1'b0, a[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      b <= '0;
    end else if (bus.t2) begin
      b <= bus.din;
    end
  end

  // Decrementing an empty counter leaves it at zero and latches err until reset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      n     <= '0;
      err_q <= 1'b0;
    end else if (bus.t5) begin
      n <= bus.din[CW-1:0];
    end else if (bus.t6) begin
      if (n == '0) begin
        err_q <= 1'b1;
      end else begin
        n <= n - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.t9;
      if (bus.t9) begin
        dout_q <= a;
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.x    = (n == '0);
  assign bus.y    = a[WIDTH-1];

`ifdef OVF_FLAG_EN
  logic ovf_q;
  logic add_ovf;
  logic sub_ovf;

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Only counts when the add/sub actually wins the A-path arbitration.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ovf_q <= 1'b0;
    end else if (!bus.t1 && ((bus.t3 && add_ovf) || (!bus.t3 && bus.t4 && sub_ovf))) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_exec_unit_xy.sv
// Self-checking bench for exec_unit_xy: directed scenarios followed by randomized microcommands
// compared against an integer-arithmetic reference model.
module tb_exec_unit_xy;

  localparam logic [9:1] NONE = 9'b000000000;
  localparam logic [9:1] T1   = 9'b000000001;
  localparam logic [9:1] T2   = 9'b000000010;
  localparam logic [9:1] T3   = 9'b000000100;
  localparam logic [9:1] T4   = 9'b000001000;
  localparam logic [9:1] T5   = 9'b000010000;
  localparam logic [9:1] T6   = 9'b000100000;
  localparam logic [9:1] T7   = 9'b001000000;
  localparam logic [9:1] T8   = 9'b010000000;
  localparam logic [9:1] T9   = 9'b100000000;

`ifdef OVF_FLAG_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk;
  logic res;
  int   errCount;
  int   checkCount;

  // Reference model state, kept as plain integers
  int mA, mB, mN, mDout, mDone, mErr, mOvf;

  exec_unit_xy_if #(.WIDTH(8)) bus ();

  exec_unit_xy #(.WIDTH(8), .CW(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mA = 0; mB = 0; mN = 0; mDout = 0; mDone = 0; mErr = 0; mOvf = 0;
  endtask

  function automatic int toSigned(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".a"},    32'(dut.a),   32'(mA));
    checkOutput({tag, ".dout"}, 32'(bus.dout), 32'(mDout));
    checkOutput({tag, ".done"}, 32'(bus.done), 32'(mDone));
    checkOutput({tag, ".x"},    32'(bus.x),    32'(mN == 0));
    checkOutput({tag, ".y"},    32'(bus.y),    32'(mA >= 128));
    checkOutput({tag, ".err"},  32'(bus.err),  32'(mErr));
    checkOutput({tag, ".ovf"},  32'(bus.ovf),  OVF_ON ? 32'(mOvf) : 32'd0);
  endtask

  // Drive one cycle of microcommands, advance the model across the edge, then compare.
  task automatic applyStimulus(input string tag, input logic [9:1] t, input int d);
    int nextA;
    int r;
    {bus.t9, bus.t8, bus.t7, bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1} = t;
    bus.din = 8'(d);
    @(posedge clk);
    nextA = mA;
    if (t[1]) nextA = d;
    else if (t[3]) begin
      nextA = (mA + mB) % 256;
      r = toSigned(mA) + toSigned(mB);
      if (r > 127 || r < -128) mOvf = 1;
    end else if (t[4]) begin
      nextA = (mA - mB + 256) % 256;
      r = toSigned(mA) - toSigned(mB);
      if (r > 127 || r < -128) mOvf = 1;
    end
    else if (t[7]) nextA = (mA * 2) % 256;
    else if (t[8]) nextA = mA / 2;
    mDone = t[9] ? 1 : 0;
    if (t[9]) mDout = mA;
    if (t[2]) mB = d;
    if (t[5]) mN = d % 16;
    else if (t[6]) begin
      if (mN == 0) mErr = 1;
      else mN = mN - 1;
    end
    mA = nextA;
    #1;
    checkAll(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges (caller is just past a posedge).
  task automatic asyncReset(input string tag);
    {bus.t9, bus.t8, bus.t7, bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1} = NONE;
    #2;
    res = 1'b1;
    #1;
    modelReset();
    checkAll(tag);
    #2;
    res = 1'b0;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    res = 1'b1;
    {bus.t9, bus.t8, bus.t7, bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1} = NONE;
    bus.din = '0;
    modelReset();
    #12;
    checkAll("por");
    res = 1'b0;

    // Load, add, output
    applyStimulus("ldA", T1, 8'h25);
    applyStimulus("ldB", T2, 8'h13);
    applyStimulus("add", T3, 0);
    checkOutput("add_const", 32'(dut.a), 32'h38);
    applyStimulus("out", T9, 0);
    checkOutput("out_dout", 32'(bus.dout), 32'h38);
    checkOutput("out_done", 32'(bus.done), 32'd1);
    applyStimulus("idle", NONE, 0);
    checkOutput("done_drop", 32'(bus.done), 32'd0);

    // Priority arbitration
    applyStimulus("prLdA", T1, 8'h10);
    applyStimulus("prLdB", T2, 8'h01);
    applyStimulus("pr137", T1 | T3 | T7, 8'h55);
    checkOutput("pr137_const", 32'(dut.a), 32'h55);
    applyStimulus("pr48", T4 | T8, 0);
    checkOutput("pr48_const", 32'(dut.a), 32'h54);

    // Counter and sticky err
    applyStimulus("cntLd", T5, 8'h03);
    applyStimulus("dec1", T6, 0);
    applyStimulus("dec2", T6, 0);
    applyStimulus("dec3", T6, 0);
    checkOutput("dec3_x", 32'(bus.x), 32'd1);
    applyStimulus("dec4", T6, 0);
    checkOutput("dec4_err", 32'(bus.err), 32'd1);
    applyStimulus("errHold", NONE, 0);

    // Shift and sign
    applyStimulus("shLd", T1, 8'h41);
    applyStimulus("shl", T7, 0);
    checkOutput("shl_y", 32'(bus.y), 32'd1);
    applyStimulus("shr", T8, 0);
    applyStimulus("outShl", T9 | T7, 0);
    checkOutput("outShl_dout", 32'(bus.dout), 32'h41);
    checkOutput("outShl_a", 32'(dut.a), 32'h82);
    applyStimulus("outTwice", T9, 0);

    // Signed overflow
    applyStimulus("ovLdA", T1, 8'h70);
    applyStimulus("ovLdB", T2, 8'h20);
    applyStimulus("ovAdd", T3, 0);
    checkOutput("ovAdd_const", 32'(bus.ovf), 32'(OVF_ON));
    applyStimulus("ovHold", T3, 0);

    // Reset mid-operation with A = 0x80
    applyStimulus("rsLdA", T1 | T5, 8'h80);
    applyStimulus("rsOut", T9 | T6, 0);
    asyncReset("midReset");
    checkOutput("midReset_x", 32'(bus.x), 32'd1);

    // Randomized microcommands
    for (int i = 0; i < 400; i++) begin
      logic [9:1] t;
      for (int k = 1; k <= 9; k++) t[k] = ($urandom_range(0, 3) == 0);
      applyStimulus("rand", t, int'($urandom_range(0, 255)));
      if (i % 137 == 136) asyncReset("randReset");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
